// File: rtl/mac_pkg.sv
// mac_pkg: shared constants and helpers for the parametrised pipelined MAC.
//   DEF_*      : default widths and multiplier depth
//   MAX_ACC_W  : widest accumulator the sat_add helper supports
//   sat_res_t  : sat_add result (overflow bit + value, low ACC_WIDTH bits meaningful)
//   sat_add()  : turns an (ACC_WIDTH+1)-bit signed sum into a clamped or wrapped
//                ACC_WIDTH result and reports whether it left the signed range
package mac_pkg;

    localparam int DEF_A_WIDTH     = 14;
    localparam int DEF_B_WIDTH     = 14;
    localparam int DEF_ACC_WIDTH   = 28;
    localparam int DEF_MULT_STAGES = 2;

    localparam int MAX_ACC_W = 64;

    typedef struct packed {
        logic                 ovf;
        logic [MAX_ACC_W-1:0] val;
    } sat_res_t;

    // sum: the (width+1)-bit signed sum, sign-extended to MAX_ACC_W+1 bits.
    // Out of range exactly when the two top bits of the narrow sum differ.
    function automatic sat_res_t sat_add(input logic [MAX_ACC_W:0] sum,
                                         input int                 width,
                                         input logic               saturate);
        sat_res_t             r;
        logic [MAX_ACC_W:0]   sh;
        logic [MAX_ACC_W-1:0] one;
        logic [MAX_ACC_W-1:0] maxv;
        one   = MAX_ACC_W'(1);
        maxv  = (one << (width - 1)) - one;  // 2^(width-1)-1
        sh    = sum >> (width - 1);          // sh[1] = sign of sum, sh[0] = result msb
        r.ovf = sh[1] ^ sh[0];
        r.val = sum[MAX_ACC_W-1:0];
        // ~maxv is -2^(width-1) sign-extended
        if (r.ovf && saturate)
            r.val = sh[1] ? ~maxv : maxv;
        return r;
    endfunction

endpackage

// File: rtl/pipe_mult.sv
// pipe_mult: signed a*b registered STAGES times, with the valid bit and a
// one-bit tag carried in a matched shift register so they emerge together.
//   clk, reset       : clock, synchronous active-high reset (valid/tag only)
//   a, b             : signed operands
//   valid_in, tag_in : qualifier and side tag for this cycle's operands
//   p                : full-width signed product, STAGES cycles later
//   valid_out, tag_out : delayed qualifier and tag aligned with p
module pipe_mult import mac_pkg::*; #(
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int B_WIDTH = DEF_B_WIDTH,
    parameter int STAGES  = DEF_MULT_STAGES
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic signed [A_WIDTH-1:0]        a,
    input  logic signed [B_WIDTH-1:0]        b,
    input  logic                             valid_in,
    input  logic                             tag_in,
    output logic signed [A_WIDTH+B_WIDTH-1:0] p,
    output logic                             valid_out,
    output logic                             tag_out
);

    localparam int PW = A_WIDTH + B_WIDTH;

    if (STAGES < 1) begin : g_bad_stages
        $error("pipe_mult: STAGES must be >= 1");
    end

    logic signed [PW-1:0]     prod;
    logic [STAGES-1:0][PW-1:0] prod_pipe;
    logic [STAGES-1:0]         vld_pipe;
    logic [STAGES-1:0]         tag_pipe;

    assign prod = a * b;

    // Data stages carry no reset; only the qualifiers need a known state.
    always_ff @(posedge clk) begin
        prod_pipe[0] <= prod;
        for (int i = 1; i < STAGES; i++)
            prod_pipe[i] <= prod_pipe[i-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[0] <= valid_in;
            tag_pipe[0] <= tag_in & valid_in;
            for (int i = 1; i < STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign p         = $signed(prod_pipe[STAGES-1]);
    assign valid_out = vld_pipe[STAGES-1];
    assign tag_out   = tag_pipe[STAGES-1];

endmodule

// File: rtl/param_pipe_mac.sv
// param_pipe_mac: signed multiply-accumulate with pipelined multiplier,
// in-band accumulator clear, optional saturation and sticky overflow.
//   clk, reset : clock, synchronous active-high reset
//   a, b       : signed operands
//   valid_in   : a, b, clear_acc valid this cycle
//   clear_acc  : this product starts a new sum (ignored when valid_in=0)
//   f          : signed accumulator value
//   valid_out  : f updated this cycle (MULT_STAGES+1 cycles after valid_in)
//   overflow   : sticky range-exceeded flag, cleared by a clear product or reset
module param_pipe_mac import mac_pkg::*; #(
    parameter int A_WIDTH     = DEF_A_WIDTH,
    parameter int B_WIDTH     = DEF_B_WIDTH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int MULT_STAGES = DEF_MULT_STAGES,
    parameter int SATURATE    = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [A_WIDTH-1:0]   a,
    input  logic signed [B_WIDTH-1:0]   b,
    input  logic                        valid_in,
    input  logic                        clear_acc,
    output logic signed [ACC_WIDTH-1:0] f,
    output logic                        valid_out,
    output logic                        overflow
);

    localparam int PW = A_WIDTH + B_WIDTH;

    if (ACC_WIDTH < PW) begin : g_bad_acc
        $error("param_pipe_mac: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
    end
    if (ACC_WIDTH > MAX_ACC_W) begin : g_bad_acc_max
        $error("param_pipe_mac: ACC_WIDTH exceeds MAX_ACC_W");
    end
    if (MULT_STAGES < 1 || MULT_STAGES > 4) begin : g_bad_stages
        $error("param_pipe_mac: MULT_STAGES must be in 1..4");
    end

    logic signed [PW-1:0] m_p;
    logic                 m_vld;
    logic                 m_clr;

    pipe_mult #(
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH),
        .STAGES  (MULT_STAGES)
    ) u_mult (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .valid_in  (valid_in),
        .tag_in    (clear_acc),
        .p         (m_p),
        .valid_out (m_vld),
        .tag_out   (m_clr)
    );

    // One guard bit above the accumulator catches any single-step overflow.
    logic signed [ACC_WIDTH:0] p_ext;
    logic signed [ACC_WIDTH:0] f_ext;
    logic signed [ACC_WIDTH:0] sum;
    sat_res_t                  res;
    logic                      unused_hi;

    assign p_ext     = (ACC_WIDTH+1)'(m_p);
    assign f_ext     = (ACC_WIDTH+1)'(f);
    assign sum       = f_ext + p_ext;
    assign res       = sat_add((MAX_ACC_W+1)'(sum), ACC_WIDTH, SATURATE != 0);
    assign unused_hi = ^res.val;

    always_ff @(posedge clk) begin
        if (reset) begin
            f         <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            valid_out <= m_vld;
            if (m_vld) begin
                if (m_clr) begin
                    f        <= p_ext[ACC_WIDTH-1:0];
                    overflow <= 1'b0;
                end else begin
                    f <= res.val[ACC_WIDTH-1:0];
                    if (res.ovf)
                        overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_param_pipe_mac.sv
module tb_param_pipe_mac;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [13:0] a, b;
    logic               valid_in, clear_acc;

    logic signed [27:0] f_def, f_wrap, f_s1, f_s4;
    logic               vo_def, vo_wrap, vo_s1, vo_s4;
    logic               ov_def, ov_wrap, ov_s1, ov_s4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_pipe_mac #(.A_WIDTH(14), .B_WIDTH(14), .ACC_WIDTH(28), .MULT_STAGES(2), .SATURATE(1)) u_def (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_acc(clear_acc),
        .f(f_def), .valid_out(vo_def), .overflow(ov_def));
    param_pipe_mac #(.A_WIDTH(14), .B_WIDTH(14), .ACC_WIDTH(28), .MULT_STAGES(2), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_acc(clear_acc),
        .f(f_wrap), .valid_out(vo_wrap), .overflow(ov_wrap));
    param_pipe_mac #(.A_WIDTH(14), .B_WIDTH(14), .ACC_WIDTH(28), .MULT_STAGES(1), .SATURATE(1)) u_s1 (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_acc(clear_acc),
        .f(f_s1), .valid_out(vo_s1), .overflow(ov_s1));
    param_pipe_mac #(.A_WIDTH(14), .B_WIDTH(14), .ACC_WIDTH(28), .MULT_STAGES(4), .SATURATE(1)) u_s4 (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_acc(clear_acc),
        .f(f_s4), .valid_out(vo_s4), .overflow(ov_s4));

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply inputs just after an edge, advance one cycle; on return the
    // outputs reflect the edge that captured these inputs.
    task automatic drv(input logic v, input logic c, input int aa, input int bb);
        valid_in  = v;
        clear_acc = c;
        a         = aa[13:0];
        b         = bb[13:0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 1'b1, 99, 99);  // clear with valid_in=0 must be ignored
    endtask

    int lat_s1, lat_def, lat_s4;
    logic signed [27:0] fl_s1, fl_def, fl_s4;

    initial begin
        reset = 1'b1; valid_in = 1'b0; clear_acc = 1'b0; a = '0; b = '0;
        drv(0, 0, 0, 0);
        drv(0, 0, 0, 0);
        chk("rst_f", f_def, 0);
        chk("rst_vo", vo_def, 0);
        chk("rst_ov", ov_def, 0);
        reset = 1'b0;
        drv(0, 0, 0, 0);

        // single product, latency 3
        drv(1, 1, 3, 4);
        drv(0, 0, 0, 0);
        chk("lat_early_vo", vo_def, 0);
        drv(0, 0, 0, 0);
        chk("single_vo", vo_def, 1);
        chk("single_f", f_def, 12);
        chk("single_ov", ov_def, 0);
        drv(0, 0, 0, 0);

        // back-to-back stream
        drv(1, 1, 3, 4);
        drv(1, 0, -5, 6);
        drv(1, 0, 7, 7);
        chk("strm0_vo", vo_def, 1); chk("strm0_f", f_def, 12);
        idle();
        chk("strm1_vo", vo_def, 1); chk("strm1_f", f_def, -18);
        idle();
        chk("strm2_vo", vo_def, 1); chk("strm2_f", f_def, 31);
        idle();
        chk("strm_end_vo", vo_def, 0); chk("strm_end_f", f_def, 31);

        // stream with a 2-cycle bubble before the last item
        drv(1, 1, 3, 4);
        drv(1, 0, -5, 6);
        idle();
        chk("bub0_f", f_def, 12);
        idle();
        chk("bub1_f", f_def, -18);
        drv(1, 0, 7, 7);
        chk("bub_hold0_vo", vo_def, 0); chk("bub_hold0_f", f_def, -18);
        idle();
        chk("bub_hold1_vo", vo_def, 0); chk("bub_hold1_f", f_def, -18);
        idle();
        chk("bub2_vo", vo_def, 1); chk("bub2_f", f_def, 31);

        // saturation vs wrap
        drv(1, 1, -8192, -8192);
        drv(1, 0, -8192, -8192);
        drv(1, 0, 1, -1);
        chk("sat0_f", f_def, 67108864); chk("wrap0_f", f_wrap, 67108864);
        chk("sat0_ov", ov_def, 0);
        drv(1, 1, 2, 2);
        chk("sat1_f", f_def, 134217727); chk("sat1_ov", ov_def, 1);
        chk("wrap1_f", f_wrap, -134217728); chk("wrap1_ov", ov_wrap, 1);
        idle();
        chk("sat2_f", f_def, 134217726); chk("sat2_ov", ov_def, 1);
        chk("wrap2_f", f_wrap, 134217727); chk("wrap2_ov", ov_wrap, 1);
        idle();
        chk("sat3_f", f_def, 4); chk("sat3_ov", ov_def, 0);
        chk("wrap3_f", f_wrap, 4); chk("wrap3_ov", ov_wrap, 0);
        idle();

        // reset one cycle after issuing a product: nothing must emerge
        drv(1, 1, 5, 5);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle();
            chk($sformatf("rst_mid_def_%0d", i), {vo_def, 28'(f_def)}, 0);
            chk($sformatf("rst_mid_s1_%0d", i), {vo_s1, 28'(f_s1)}, 0);
            chk($sformatf("rst_mid_s4_%0d", i), {vo_s4, 28'(f_s4)}, 0);
        end

        // latency per depth: cycle 1 is the edge that captures the input
        lat_s1 = 0; lat_def = 0; lat_s4 = 0;
        fl_s1 = '0; fl_def = '0; fl_s4 = '0;
        drv(1, 1, 2, 3);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (cyc > 1) idle();
            if (vo_s1  && lat_s1  == 0) begin lat_s1  = cyc; fl_s1  = f_s1;  end
            if (vo_def && lat_def == 0) begin lat_def = cyc; fl_def = f_def; end
            if (vo_s4  && lat_s4  == 0) begin lat_s4  = cyc; fl_s4  = f_s4;  end
        end
        chk("lat_s1", lat_s1, 2);   chk("lat_s1_f", fl_s1, 6);
        chk("lat_def", lat_def, 3); chk("lat_def_f", fl_def, 6);
        chk("lat_s4", lat_s4, 5);   chk("lat_s4_f", fl_s4, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_pipe_mac.md
Name: param_pipe_mac

Overview:
- Parametrised successor to the fixed 14x14 two-stage-multiplier MAC: signed multiply-accumulate with configurable operand and accumulator widths and a configurable multiplier pipeline depth.
- Adds an in-band accumulator clear that travels with the data, optional saturating accumulation, and a sticky overflow flag.
- Sits in the convolution datapath as the per-lane MAC; the generator instantiates one per output channel.

Parameters:
- A_WIDTH, 14: signed width of operand a.
- B_WIDTH, 14: signed width of operand b.
- ACC_WIDTH, 28: signed accumulator/output width. Must satisfy ACC_WIDTH >= A_WIDTH+B_WIDTH; elaboration error otherwise.
- MULT_STAGES, 2: register stages in the multiplier, range 1..4. Elaboration error outside that range.
- SATURATE, 1: 1 = clamp accumulation to the ACC_WIDTH signed range; 0 = two's-complement wrap.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  A_WIDTH  signed operand.
- b  input  B_WIDTH  signed operand.
- valid_in  input  1  a, b and clear_acc are valid this cycle.
- clear_acc  input  1  this product starts a new accumulation. Sampled only when valid_in=1.
- f  output  ACC_WIDTH  signed accumulator value.
- valid_out  output  1  f updated this cycle.
- overflow  output  1  sticky: saturation or wrap occurred since last clear/reset.

Behaviour:
- Reset (sync, high): f=0, valid_out=0, overflow=0; all pipeline valid and clear tags cleared. Pipeline data registers need not reset.
- Multiplier: p = a*b, full signed product of A_WIDTH+B_WIDTH bits, registered MULT_STAGES times. The valid_in and clear_acc tags travel alongside in a matched shift register.
- Accumulate stage, one register after the multiplier output. When the tagged valid=1:
  - clear tag=1: f <= sign-extend(p); overflow <= 0.
  - clear tag=0: s = f + sign-extend(p), computed at ACC_WIDTH+1 bits.
  - If s exceeds the ACC_WIDTH range: overflow <= 1. With SATURATE=1, f <= 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) according to the sign of s. With SATURATE=0, f <= s[ACC_WIDTH-1:0].
  - valid_out <= 1.
- When the tagged valid=0: f and overflow hold; valid_out <= 0.
- Latency: valid_in at cycle N gives valid_out=1 at the end of cycle N+MULT_STAGES+1 (3 cycles at default).
- Throughput: one product per cycle. Bubbles (valid_in=0) are allowed anywhere and do not disturb f.
- valid_in=0 with clear_acc=1: clear is ignored.
- Clear takes effect in data order. Products issued before the clear accumulate into the old sum; the clearing product becomes the first term of the new sum.
- Reset mid-operation: in-flight products are discarded. No valid_out occurs for them after reset deasserts.
- Back-to-back clears: each valid_out shows only that cycle's product.
- overflow stays high through later in-range accumulations until a clear product or reset.

Decomposition:
- Package mac_pkg holds:
  - the default width constants;
  - a sat_add function (ACC_WIDTH+1 sum to clamped or wrapped result plus overflow bit), parametrised through a width argument.
- Sub-module pipe_mult (params A_WIDTH, B_WIDTH, STAGES; ports clk, reset, a, b, valid_in, tag_in, p, valid_out, tag_out). It carries the product, the valid bit and the clear tag with matched latency.
- param_pipe_mac instantiates pipe_mult plus the accumulate stage.

Test Plan:
- Defaults, reset then valid_in=1, clear_acc=1, a=3, b=4 -> exactly 3 cycles later valid_out=1, f=12, overflow=0.
- Stream (clear,3,4),(0,-5,6),(0,7,7) back-to-back -> valid_out on 3 consecutive cycles with f=12, -18, 31.
- Same stream with a 2-cycle valid_in=0 bubble before the last item -> f holds -18 for 2 cycles with valid_out=0, then f=31.
- SATURATE=1: (clear,-8192,-8192) then (0,-8192,-8192) -> f=67108864, then f=134217727 with overflow=1. A following (0,1,-1) gives f=134217726 and overflow stays 1. A following (clear,2,2) gives f=4 and overflow=0.
- SATURATE=0, same first two items -> second f=-134217728 (wrap), overflow=1.
- Reset asserted 1 cycle after a valid product is issued -> valid_out=0 and f=0 on every cycle until new input. Repeat with MULT_STAGES=1 and 4 and check latencies of 2 and 5.
